i2s_rx: RTL and testbench

I2S receiver that deserializes stereo ADC samples from the codec's serial data line into parallel 24-bit left/right words. It runs entirely in the `mck` domain and treats `bck`/`lrck` as data. `clk_div` drives those same signals to the codec, so the receiver oversamples and edge-detects them. It is the capture front end of the pedal's audio path and hands each completed stereo pair to the DSP through a valid/ready handshake.

---
 rtl/i2s_rx_pkg.sv | 20 ++
 rtl/i2s_sync.sv | 33 +++
 rtl/i2s_rx.sv | 191 +++++++++++++++++++
 tb/tb_i2s_rx.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_rx_pkg.sv
// Shared I2S receiver definitions: FSM state encoding, default word and slot widths.
// Latency: none, declarations only.
// Backpressure: not applicable.
package i2s_rx_pkg;

   // Receiver framing states.
   typedef enum logic [1:0] {
      I2S_SYNC  = 2'd0,
      I2S_LEFT  = 2'd1,
      I2S_RIGHT = 2'd2
   } i2s_state_t;

   // Defaults shared with the clock divider that generates bck/lrck (64*fs framing).
   localparam int DEF_DATA_BITS = 24;
   localparam int DEF_SLOT_BITS = 32;

   // Bit counter width; covers slot lengths up to 63.
   localparam int CNT_W = 6;

endpackage

// File: rtl/i2s_sync.sv
// Two-flop synchronizer with a registered rising-edge detect for one mck-sampled line.
// Latency: rise pulses 3 mck cycles after the input rises; q is delayed to line up with rise.
// Backpressure: none, free-running.
module i2s_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise
);

   logic s1;
   logic s2;
   logic s3;

   // Metastability chain, one extra stage so q is aligned with the registered edge pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         s3   <= 1'b0;
         rise <= 1'b0;
      end else begin
         s1   <= d;
         s2   <= s1;
         s3   <= s2;
         rise <= s2 & ~s3;
      end
   end

   assign q = s3;

endmodule

// File: rtl/i2s_rx.sv
// I2S (Philips framing) receiver: deserializes sdin into 24-bit left/right words in the mck domain.
// Latency: valid rises 1 mck after the bit event that sees ws fall (4 mck after the bck edge launches).
// Backpressure: valid/ready; an unconsumed pair is overwritten by the next one and sets sticky overrun.
module i2s_rx
   import i2s_rx_pkg::*;
#(
   parameter int DATA_BITS = DEF_DATA_BITS,
   parameter int SLOT_BITS = DEF_SLOT_BITS
) (
   input  logic                 mck,
   input  logic                 en,
   input  logic                 bck,
   input  logic                 lrck,
   input  logic                 sdin,
   output logic [DATA_BITS-1:0] left,
   output logic [DATA_BITS-1:0] right,
   output logic                 valid,
   input  logic                 ready,
   output logic                 overrun,
   output logic                 frame_err
);

   localparam logic [CNT_W-1:0]     SLOT_LIM = CNT_W'(SLOT_BITS);
   localparam logic [CNT_W-1:0]     DATA_LIM = CNT_W'(DATA_BITS);
   localparam logic [DATA_BITS-1:0] MSB_ONE  = {1'b1, {(DATA_BITS-1){1'b0}}};

   logic                 bit_evt;
   logic                 ws;
   logic                 sd;
   logic                 unused_bck_lvl;
   logic                 unused_ws_rise;
   logic                 unused_sd_rise;

   i2s_state_t           state;
   i2s_state_t           state_nxt;
   logic [CNT_W-1:0]     bitcnt;
   logic [CNT_W-1:0]     bitcnt_nxt;
   logic                 ws_prev;
   logic [DATA_BITS-1:0] shift_l;
   logic [DATA_BITS-1:0] shift_r;
   logic [DATA_BITS-1:0] bit_mask;

   logic                 wr_l;
   logic                 wr_r;
   logic                 clr_l;
   logic                 clr_r;
   logic                 commit;
   logic                 err;

   // Identical synchronizers keep bck, lrck and sdin aligned to each other.
   i2s_sync u_sync_bck (
      .clk   (mck),
      .rst_n (en),
      .d     (bck),
      .q     (unused_bck_lvl),
      .rise  (bit_evt)
   );

   i2s_sync u_sync_ws (
      .clk   (mck),
      .rst_n (en),
      .d     (lrck),
      .q     (ws),
      .rise  (unused_ws_rise)
   );

   i2s_sync u_sync_sd (
      .clk   (mck),
      .rst_n (en),
      .d     (sdin),
      .q     (sd),
      .rise  (unused_sd_rise)
   );

   // Writing bit bitcnt at position DATA_BITS-1-bitcnt is an MSB-first shift that is already
   // left-justified, so a short slot leaves its unfilled LSBs at zero with no fix-up at commit.
   assign bit_mask = MSB_ONE >> bitcnt;

   // FSM state and bit counter registers.
   always_ff @(posedge mck or negedge en) begin
      if (!en) begin
         state  <= I2S_SYNC;
         bitcnt <= '0;
      end else begin
         state  <= state_nxt;
         bitcnt <= bitcnt_nxt;
      end
   end

   // Next-state and datapath strobes, evaluated only on bit events.
   always_comb begin
      state_nxt  = state;
      bitcnt_nxt = bitcnt;
      wr_l       = 1'b0;
      wr_r       = 1'b0;
      clr_l      = 1'b0;
      clr_r      = 1'b0;
      commit     = 1'b0;
      err        = 1'b0;
      if (bit_evt) begin
         case (state)
            I2S_SYNC: begin
               // Only a ws fall marks a left-slot start; anything else is mid-frame.
               if (ws_prev && !ws) begin
                  state_nxt  = I2S_LEFT;
                  bitcnt_nxt = '0;
                  clr_l      = 1'b1;
               end
            end
            I2S_LEFT: begin
               if (!ws_prev && ws) begin
                  state_nxt  = I2S_RIGHT;
                  bitcnt_nxt = '0;
                  clr_r      = 1'b1;
               end else if (bitcnt >= SLOT_LIM) begin
                  err        = 1'b1;
                  state_nxt  = I2S_SYNC;
                  bitcnt_nxt = '0;
                  clr_l      = 1'b1;
                  clr_r      = 1'b1;
               end else begin
                  bitcnt_nxt = bitcnt + 1'b1;
                  wr_l       = (bitcnt < DATA_LIM);
               end
            end
            I2S_RIGHT: begin
               if (ws_prev && !ws) begin
                  commit     = 1'b1;
                  state_nxt  = I2S_LEFT;
                  bitcnt_nxt = '0;
                  clr_l      = 1'b1;
               end else if (bitcnt >= SLOT_LIM) begin
                  err        = 1'b1;
                  state_nxt  = I2S_SYNC;
                  bitcnt_nxt = '0;
                  clr_l      = 1'b1;
                  clr_r      = 1'b1;
               end else begin
                  bitcnt_nxt = bitcnt + 1'b1;
                  wr_r       = (bitcnt < DATA_LIM);
               end
            end
            default: begin
               state_nxt  = I2S_SYNC;
               bitcnt_nxt = '0;
            end
         endcase
      end
   end

   // Shift registers, word-select history, output pair and handshake flags.
   always_ff @(posedge mck or negedge en) begin
      if (!en) begin
         ws_prev   <= 1'b0;
         shift_l   <= '0;
         shift_r   <= '0;
         left      <= '0;
         right     <= '0;
         valid     <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (bit_evt) begin
            ws_prev <= ws;
         end
         if (clr_l) begin
            shift_l <= '0;
         end else if (wr_l && sd) begin
            shift_l <= shift_l | bit_mask;
         end
         if (clr_r) begin
            shift_r <= '0;
         end else if (wr_r && sd) begin
            shift_r <= shift_r | bit_mask;
         end
         // A commit wins over an accept in the same cycle; the new pair stays valid.
         if (commit) begin
            left  <= shift_l;
            right <= shift_r;
            valid <= 1'b1;
            if (valid && !ready) begin
               overrun <= 1'b1;
            end
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
         frame_err <= err;
      end
   end

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: slot-level stimulus with a transaction-level expected-output model.
// Latency: model expects commit/frame_err 4 mck after the bck rising edge that carries them.
// Backpressure: ready driven as a hold level plus an optional one-cycle pulse aimed at a commit edge.
module tb_i2s_rx;

   localparam int DB = 24;
   localparam int SB = 32;
   localparam logic [DB-1:0] TOP = {1'b1, {(DB-1){1'b0}}};

   logic          mck = 1'b0;
   logic          en;
   logic          bck;
   logic          lrck;
   logic          sdin;
   logic          ready;
   logic [DB-1:0] left;
   logic [DB-1:0] right;
   logic          valid;
   logic          overrun;
   logic          frame_err;

   always #5 mck = ~mck;

   i2s_rx #(.DATA_BITS(DB), .SLOT_BITS(SB)) dut (
      .mck       (mck),
      .en        (en),
      .bck       (bck),
      .lrck      (lrck),
      .sdin      (sdin),
      .left      (left),
      .right     (right),
      .valid     (valid),
      .ready     (ready),
      .overrun   (overrun),
      .frame_err (frame_err)
   );

   // Expected events, stamped with the mck edge count at which they must take effect.
   typedef struct {
      int            at;
      bit            commit;
      bit            err;
      logic [DB-1:0] l;
      logic [DB-1:0] r;
   } ev_t;
   ev_t evq[$];

   int   cyc = 0;
   logic ready_s = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   err_seen = 0;

   bit   ready_hold = 1'b0;
   int   rdy_pulse_at = -1;
   bit   pulse_next = 1'b0;

   // Stream generator bookkeeping (slot level).
   bit            in_frame = 1'b0;
   bit            got_r = 1'b0;
   logic          prev_ws = 1'b0;
   logic          carry = 1'b0;
   logic [DB-1:0] pend_l = '0;
   logic [DB-1:0] pend_r = '0;

   // Model of the outputs.
   logic          m_valid = 1'b0;
   logic          m_ovr = 1'b0;
   logic          m_err = 1'b0;
   logic [DB-1:0] m_l = '0;
   logic [DB-1:0] m_r = '0;

   always @(posedge mck) begin
      cyc     <= cyc + 1;
      ready_s <= ready;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Bit j (0 = MSB) of a wbits-wide word; zero outside the word.
   function automatic logic get_bit(input logic [DB-1:0] w, input int wbits, input int j);
      logic [DB-1:0] t;
      if (j < 0 || j >= wbits) return 1'b0;
      t = w >> (wbits - 1 - j);
      return t[0];
   endfunction

   // Word the receiver must deliver: the bits after the ws-change bit, first DB of them, left-justified.
   function automatic logic [DB-1:0] exp_word(input logic [DB-1:0] w, input int wbits, input int slen);
      logic [DB-1:0] x;
      x = '0;
      for (int j = 0; j < slen - 1 && j < DB; j++) begin
         if (get_bit(w, wbits, j)) x = x | (TOP >> j);
      end
      return x;
   endfunction

   task automatic tick();
      @(negedge mck);
      ready = ready_hold | (cyc + 1 == rdy_pulse_at);
   endtask

   // One bck period: data changes with bck low, rising edge after 4 mck.
   task automatic drive_bit(input logic ws, input logic d, input bit c, input bit e,
                            input logic [DB-1:0] cl, input logic [DB-1:0] cr);
      ev_t ev;
      tick();
      bck  = 1'b0;
      lrck = ws;
      sdin = d;
      repeat (3) tick();
      tick();
      bck = 1'b1;
      if (c || e) begin
         ev.at = cyc + 4;
         ev.commit = c;
         ev.err = e;
         ev.l = cl;
         ev.r = cr;
         evq.push_back(ev);
         if (c && pulse_next) begin
            rdy_pulse_at = cyc + 4;
            pulse_next = 1'b0;
         end
      end
      repeat (3) tick();
   endtask

   // One ws slot of slen bck periods carrying a wbits word MSB-first (Philips: MSB at period 1).
   task automatic send_slot(input logic ws, input logic [DB-1:0] w, input int wbits, input int slen);
      logic          d;
      bit            c;
      bit            e;
      logic [DB-1:0] cl;
      logic [DB-1:0] cr;
      for (int k = 0; k < slen; k++) begin
         d  = (k == 0) ? carry : get_bit(w, wbits, k - 1);
         c  = 1'b0;
         e  = 1'b0;
         cl = pend_l;
         cr = pend_r;
         if (k == 0 && ws != prev_ws) begin
            if (en) begin
               if (!ws) begin
                  c = in_frame && got_r;
                  in_frame = 1'b1;
                  got_r = 1'b0;
                  pend_l = exp_word(w, wbits, slen);
               end else if (in_frame) begin
                  got_r = 1'b1;
                  pend_r = exp_word(w, wbits, slen);
               end
            end
            prev_ws = ws;
         end
         if (en && in_frame && k == SB + 1) begin
            e = 1'b1;
            in_frame = 1'b0;
         end
         drive_bit(ws, d, c, e, cl, cr);
      end
      carry = get_bit(w, wbits, slen - 1);
   endtask

   // Advance the model and compare every DUT output once per mck cycle.
   always begin
      bit            c;
      bit            e;
      logic [DB-1:0] cl;
      logic [DB-1:0] cr;
      ev_t           ev;
      @(negedge mck);
      #1;
      if (!en) begin
         m_valid = 1'b0;
         m_ovr   = 1'b0;
         m_err   = 1'b0;
         m_l     = '0;
         m_r     = '0;
         evq.delete();
      end else begin
         c  = 1'b0;
         e  = 1'b0;
         cl = '0;
         cr = '0;
         while (evq.size() > 0 && evq[0].at == cyc) begin
            ev = evq.pop_front();
            if (ev.err) e = 1'b1;
            if (ev.commit) begin
               c  = 1'b1;
               cl = ev.l;
               cr = ev.r;
            end
         end
         if (c) begin
            if (m_valid && !ready_s) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_l = cl;
            m_r = cr;
         end else if (m_valid && ready_s) begin
            m_valid = 1'b0;
         end
         m_err = e;
      end
      if (frame_err === 1'b1) err_seen++;
      chk($sformatf("outputs@%0d {valid,overrun,frame_err,left,right}", cyc),
          64'({valid, overrun, frame_err, left, right}),
          64'({m_valid, m_ovr, m_err, m_l, m_r}));
   end

   initial begin
      en    = 1'b0;
      bck   = 1'b0;
      lrck  = 1'b0;
      sdin  = 1'b0;
      ready = 1'b0;
      repeat (4) tick();
      chk("reset_outputs", 64'({valid, overrun, frame_err, left, right}), 64'd0);

      // Line toggles while held in reset: nothing may be captured.
      send_slot(1'b1, 24'hFFFFFF, 24, 32);
      send_slot(1'b0, 24'hABCDEF, 24, 8);
      chk("reset_hold_valid", 64'(valid), 64'd0);
      chk("reset_hold_left", 64'(left), 64'd0);
      tick();
      bck = 1'b0;
      repeat (4) tick();
      en = 1'b1;

      // Partial frame in progress at release is skipped; first pair is A5A5A5/5A5A5A.
      send_slot(1'b1, 24'h135790, 24, 32);
      send_slot(1'b0, 24'hA5A5A5, 24, 32);
      chk("no_partial_commit", 64'(valid), 64'd0);
      send_slot(1'b1, 24'h5A5A5A, 24, 32);
      send_slot(1'b0, 24'h111111, 24, 32);
      chk("basic_left", 64'(left), 64'hA5A5A5);
      chk("basic_right", 64'(right), 64'h5A5A5A);
      chk("basic_valid", 64'(valid), 64'd1);

      // Accept exactly in the commit cycle: new pair stays valid, no overrun.
      send_slot(1'b1, 24'h222222, 24, 32);
      pulse_next = 1'b1;
      send_slot(1'b0, 24'h333333, 24, 32);
      chk("simul_valid", 64'(valid), 64'd1);
      chk("simul_left", 64'(left), 64'h111111);
      chk("simul_right", 64'(right), 64'h222222);
      chk("simul_overrun", 64'(overrun), 64'd0);
      ready_hold = 1'b1;
      repeat (2) tick();
      chk("accept_clears_valid", 64'(valid), 64'd0);

      // Short slots: 16 bck per slot loses the LSB to the next slot; 20 bck keeps all 16 bits.
      send_slot(1'b1, 24'h444444, 24, 32);
      send_slot(1'b0, 24'h00BEEF, 16, 16);
      send_slot(1'b1, 24'h00CAFE, 16, 16);
      send_slot(1'b0, 24'h00BEEF, 16, 20);
      chk("short16_left", 64'(left), 64'hBEEE00);
      chk("short16_right", 64'(right), 64'hCAFE00);
      send_slot(1'b1, 24'h001234, 16, 20);
      send_slot(1'b0, 24'h000000, 24, 32);
      chk("short20_left", 64'(left), 64'hBEEF00);
      chk("short20_right", 64'(right), 64'h123400);

      // lrck held low for 40 bck: one frame_err, resync, no commit of the broken frame.
      send_slot(1'b1, 24'h555555, 24, 32);
      send_slot(1'b0, 24'h666666, 24, 40);
      send_slot(1'b1, 24'h777777, 24, 32);
      send_slot(1'b0, 24'h0ABCDE, 24, 32);
      chk("ferr_pulses", 64'(err_seen), 64'd1);
      chk("ferr_no_commit_left", 64'(left), 64'h000000);
      chk("ferr_no_commit_right", 64'(right), 64'h555555);
      send_slot(1'b1, 24'hFEDCBA, 24, 32);
      send_slot(1'b0, 24'h000001, 24, 32);
      chk("recover_left", 64'(left), 64'h0ABCDE);
      chk("recover_right", 64'(right), 64'hFEDCBA);
      ready_hold = 1'b0;

      // Two pairs with ready low: second overwrites first and sets overrun.
      send_slot(1'b1, 24'h00000A, 24, 32);
      send_slot(1'b0, 24'h7FFFFF, 24, 32);
      chk("ovr_first_valid", 64'(valid), 64'd1);
      chk("ovr_not_yet", 64'(overrun), 64'd0);
      send_slot(1'b1, 24'h800000, 24, 32);
      send_slot(1'b0, 24'h000000, 24, 32);
      chk("ovr_set", 64'(overrun), 64'd1);
      chk("ovr_left", 64'(left), 64'h7FFFFF);
      chk("ovr_right", 64'(right), 64'h800000);
      ready_hold = 1'b1;
      repeat (2) tick();
      chk("ovr_accept_clears", 64'(valid), 64'd0);
      chk("ovr_sticky", 64'(overrun), 64'd1);

      tick();
      bck = 1'b0;
      repeat (16) tick();
      chk("events_drained", 64'(evq.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
